// File: rtl/uart_rx.sv
// 8N1 UART receiver with an optional trailing CRC-8 byte that checks the data byte.
// The serial line is synchronized, then sampled mid-bit using a per-frame latched divider.
module uart_rx #(
    parameter logic [7:0] CRC_POLY    = 8'h07,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        rx_i,
    input  logic        rx_en_i,
    input  logic        crc_en_i,
    input  logic [15:0] clock_divider_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    output logic        frame_err_o,
    output logic        crc_err_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, CRC_START, CRC_DATA, CRC_STOP, DONE
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_line_d;
    logic [15:0]            r_n;
    logic [15:0]            r_cnt;
    logic                   r_crc_en;
    logic                   r_armed;
    logic [2:0]             r_bit;
    logic [7:0]             r_shift;
    logic [7:0]             r_byte;
    logic [7:0]             r_data;
    logic                   r_valid;
    logic                   r_ferr;
    logic                   r_crc_err;

    logic                   w_line;
    logic                   w_fall;
    logic                   w_tick;
    logic [7:0]             w_crc;

    // MSB-first CRC-8, zero init, no reflection or final XOR.
    function automatic logic [7:0] crc8(input logic [7:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ CRC_POLY;
            else             c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    assign w_line = r_sync[SYNC_STAGES-1];
    assign w_fall = r_line_d & ~w_line;
    assign w_tick = (r_cnt == 16'd0);
    assign w_crc  = crc8(r_byte);

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_sync    <= '1;
            r_line_d  <= 1'b1;
            r_n       <= '0;
            r_cnt     <= '0;
            r_crc_en  <= 1'b0;
            r_armed   <= 1'b0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_byte    <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_crc_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments everywhere here, so every branch reads the
            // pre-edge values of r_cnt/r_shift/r_state regardless of statement order.
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_crc_err <= 1'b0;
            r_sync[0] <= rx_i;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_line_d  <= w_line;

            if (!rx_en_i) begin
                r_state <= IDLE;
                r_armed <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_fall && clock_divider_i >= 16'd2) begin
                            r_n      <= clock_divider_i;
                            r_crc_en <= crc_en_i;
                            r_cnt    <= (clock_divider_i >> 1) - 16'd1;
                            r_bit    <= '0;
                            r_state  <= START;
                        end
                    end
                    START: begin
                        if (w_tick) begin
                            r_cnt   <= r_n - 16'd1;
                            r_state <= w_line ? IDLE : DATA;
                        end else begin
                            r_cnt <= r_cnt - 16'd1;
                        end
                    end
                    DATA, CRC_DATA: begin
                        if (w_tick) begin
                            r_shift <= {w_line, r_shift[7:1]};
                            r_cnt   <= r_n - 16'd1;
                            r_bit   <= r_bit + 3'd1;
                            if (r_bit == 3'd7) r_state <= (r_state == DATA) ? STOP : CRC_STOP;
                        end else begin
                            r_cnt <= r_cnt - 16'd1;
                        end
                    end
                    STOP: begin
                        if (w_tick) begin
                            if (!w_line) begin
                                r_ferr  <= 1'b1;
                                r_state <= IDLE;
                            end else if (r_crc_en) begin
                                r_byte  <= r_shift;
                                r_armed <= 1'b0;
                                r_state <= CRC_START;
                            end else begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                                r_state <= DONE;
                            end
                        end else begin
                            r_cnt <= r_cnt - 16'd1;
                        end
                    end
                    CRC_START: begin
                        // Unarmed: wait indefinitely for the CRC byte's start edge.
                        if (!r_armed) begin
                            if (w_fall) begin
                                r_armed <= 1'b1;
                                r_cnt   <= (r_n >> 1) - 16'd1;
                            end
                        end else if (w_tick) begin
                            r_armed <= 1'b0;
                            r_cnt   <= r_n - 16'd1;
                            r_bit   <= '0;
                            r_state <= w_line ? IDLE : CRC_DATA;
                        end else begin
                            r_cnt <= r_cnt - 16'd1;
                        end
                    end
                    CRC_STOP: begin
                        if (w_tick) begin
                            if (!w_line) begin
                                r_ferr <= 1'b1;
                            end else begin
                                r_data    <= r_byte;
                                r_valid   <= 1'b1;
                                r_crc_err <= (w_crc != r_shift);
                            end
                            r_state <= w_line ? DONE : IDLE;
                        end else begin
                            r_cnt <= r_cnt - 16'd1;
                        end
                    end
                    DONE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign rx_data_o   = r_data;
    assign rx_valid_o  = r_valid;
    assign frame_err_o = r_ferr;
    assign crc_err_o   = r_crc_err;
    assign busy_o      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames for uart_rx, checked against a frame-level model
// (expected byte / pulses computed from the frame rules, CRC by polynomial division).
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        rx_i = 1'b1;
    logic        rx_en_i = 1'b1;
    logic        crc_en_i = 1'b0;
    logic [15:0] clock_divider_i = 16'd16;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o, frame_err_o, crc_err_o, busy_o;

    uart_rx dut (
        .clk(clk), .rst_i(rst_i), .rx_i(rx_i), .rx_en_i(rx_en_i), .crc_en_i(crc_en_i),
        .clock_divider_i(clock_divider_i), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
        .frame_err_o(frame_err_o), .crc_err_o(crc_err_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Cumulative pulse monitor, sampled on the falling edge.
    int  n_valid = 0, n_ferr = 0, n_crc = 0, n_busy = 0, n_viol = 0;
    longint t_valid = 0;
    logic p_valid = 1'b0, p_ferr = 1'b0, p_crc = 1'b0;
    always @(negedge clk) begin
        if (rx_valid_o) begin n_valid++; t_valid = $time; end
        if (frame_err_o) n_ferr++;
        if (crc_err_o) n_crc++;
        if (busy_o) n_busy++;
        if ((rx_valid_o && p_valid) || (frame_err_o && p_ferr) || (crc_err_o && p_crc) ||
            (rx_valid_o && frame_err_o) || (crc_err_o && !rx_valid_o)) n_viol++;
        p_valid = rx_valid_o; p_ferr = frame_err_o; p_crc = crc_err_o;
    end

    int n_total = 0, n_pass = 0;
    int b_valid, b_ferr, b_crc, b_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic snap();
        b_valid = n_valid; b_ferr = n_ferr; b_crc = n_crc; b_busy = n_busy;
    endtask

    task automatic check_pulses(input string tag, input int ev, input int ef, input int ec);
        check({tag, "_valid"}, n_valid - b_valid, ev);
        check({tag, "_ferr"}, n_ferr - b_ferr, ef);
        check({tag, "_crc"}, n_crc - b_crc, ec);
    endtask

    // Reference CRC: remainder of d * x^8 divided by x^8 + poly.
    function automatic logic [7:0] ref_crc(input logic [7:0] d);
        logic [15:0] r;
        logic [15:0] p;
        r = {d, 8'h00};
        p = 16'h0107;
        for (int b = 15; b >= 8; b--) if (r[b]) r = r ^ (p << (b - 8));
        return r[7:0];
    endfunction

    task automatic idle(input int k);
        rx_i = 1'b1;
        repeat (k) @(negedge clk);
    endtask

    task automatic send_head(input logic [7:0] d, input int nbits, input int n);
        rx_i = 1'b0;
        repeat (n) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx_i = d[i];
            repeat (n) @(negedge clk);
        end
    endtask

    task automatic send_tail(input logic [7:0] d, input int from, input logic stop, input int n);
        for (int i = from; i < 8; i++) begin
            rx_i = d[i];
            repeat (n) @(negedge clk);
        end
        rx_i = stop;
        repeat (n) @(negedge clk);
        rx_i = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop, input int n);
        send_head(d, 0, n);
        send_tail(d, 0, stop, n);
    endtask

    initial begin
        logic [7:0] exp_data;
        longint     t0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data", rx_data_o, 8'h00);
        check("rst_valid", rx_valid_o, 1'b0);
        check("rst_ferr", frame_err_o, 1'b0);
        check("rst_crc", crc_err_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        rst_i = 1'b0;
        idle(5);

        // Plain frame, including pulse latency relative to the start-bit drop
        snap();
        t0 = $time;
        send_byte(8'hA5, 1'b1, 16);
        idle(20);
        check_pulses("a5", 1, 0, 0);
        check("a5_data", rx_data_o, 8'hA5);
        check("a5_latency", 32'((t_valid - t0) / 10), 32'(SYNC + 1 + 8 + 9 * 16));

        // CRC framing: good and bad reference byte
        crc_en_i = 1'b1;
        snap();
        send_byte(8'hA5, 1'b1, 16); idle(7);
        send_byte(8'h72, 1'b1, 16); idle(20);
        check_pulses("crc_ok", 1, 0, 0);
        check("crc_ok_data", rx_data_o, 8'hA5);
        snap();
        send_byte(8'hA5, 1'b1, 16); idle(7);
        send_byte(8'h73, 1'b1, 16); idle(20);
        check_pulses("crc_bad", 1, 0, 1);
        check("crc_bad_data", rx_data_o, 8'hA5);
        crc_en_i = 1'b0;

        // Stop bit low
        snap();
        send_byte(8'h3C, 1'b0, 16);
        idle(20);
        check_pulses("stop_low", 0, 1, 0);
        check("stop_low_data", rx_data_o, 8'hA5);

        // Short glitch: false start, busy for exactly N/2 cycles after detection
        snap();
        rx_i = 1'b0;
        repeat (3) @(negedge clk);
        check("glitch_busy_on", busy_o, 1'b1);
        repeat (1) @(negedge clk);
        rx_i = 1'b1;
        repeat (6) @(negedge clk);
        check("glitch_busy_last", busy_o, 1'b1);
        repeat (1) @(negedge clk);
        check("glitch_busy_off", busy_o, 1'b0);
        idle(20);
        check_pulses("glitch", 0, 0, 0);

        // Enable dropped mid-frame, then a clean frame
        snap();
        send_head(8'h55, 4, 16);
        rx_en_i = 1'b0;
        send_tail(8'h55, 4, 1'b1, 16);
        idle(20);
        check_pulses("en_drop", 0, 0, 0);
        check("en_drop_busy", busy_o, 1'b0);
        rx_en_i = 1'b1;
        idle(5);
        send_byte(8'h0F, 1'b1, 16);
        idle(20);
        check("en_after_data", rx_data_o, 8'h0F);

        // Reset mid-frame
        snap();
        send_head(8'hC3, 3, 16);
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_data", rx_data_o, 8'h00);
        check("midrst_busy", busy_o, 1'b0);
        check("midrst_valid", rx_valid_o, 1'b0);
        send_tail(8'hC3, 3, 1'b1, 16);
        rst_i = 1'b0;
        idle(10);
        check_pulses("midrst", 0, 0, 0);
        snap();
        send_byte(8'h81, 1'b1, 16);
        idle(20);
        check_pulses("after_rst", 1, 0, 0);
        check("after_rst_data", rx_data_o, 8'h81);

        // Divider below 2: line ignored entirely
        for (int dv = 0; dv < 2; dv++) begin
            clock_divider_i = 16'(dv);
            snap();
            send_byte(8'h5A, 1'b1, 16);
            idle(20);
            check("ndiv_busy", n_busy - b_busy, 0);
            check("ndiv_valid", n_valid - b_valid, 0);
        end

        // Randomized frames against the frame-level model
        exp_data = rx_data_o === 8'h81 ? 8'h81 : 8'h81;
        for (int it = 0; it < 14; it++) begin
            logic [7:0] d, cb;
            logic       ce, s1, s2, good;
            int         n, ev, ef, ec;
            d    = 8'($urandom);
            n    = $urandom_range(2, 24);
            ce   = 1'($urandom);
            s1   = ($urandom_range(0, 3) != 0);
            s2   = ($urandom_range(0, 3) != 0);
            good = 1'($urandom);
            cb   = good ? ref_crc(d) : (ref_crc(d) ^ 8'($urandom_range(1, 255)));
            clock_divider_i = 16'(n);
            crc_en_i = ce;
            ev = 0; ef = 0; ec = 0;
            if (!s1) ef = 1;
            else if (!ce) begin ev = 1; exp_data = d; end
            else if (!s2) ef = 1;
            else begin ev = 1; exp_data = d; ec = (cb != ref_crc(d)) ? 1 : 0; end
            snap();
            send_byte(d, s1, n);
            idle(n + 6);
            if (s1 && ce) begin
                send_byte(cb, s2, n);
                idle(n + 6);
            end
            idle(2 * n + 6);
            check_pulses("rand", ev, ef, ec);
            check("rand_data", rx_data_o, exp_data);
        end

        check("pulse_rules", n_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CRC_POLY, default 8'h07, CRC-8 generator polynomial (implicit x^8).
REQ-002 Parameter SYNC_STAGES, default 2, flip-flop stages synchronizing rx_i.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 rx_i  input  1  serial line; idle high; asynchronous to clk.
REQ-006 rx_en_i  input  1  receiver enable.
REQ-007 crc_en_i  input  1  CRC framing enable.
REQ-008 clock_divider_i  input  16  clk cycles per bit period (N).
REQ-009 rx_data_o  output  8  last received data byte; held between frames.
REQ-010 rx_valid_o  output  1  one-cycle pulse: frame complete, rx_data_o updated.
REQ-011 frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
REQ-012 crc_err_o  output  1  one-cycle pulse, coincident with rx_valid_o, on CRC mismatch.
REQ-013 busy_o  output  1  high in every state except IDLE.

Function
REQ-014 Frame format SHALL be 1 start bit (low), 8 data bits LSB first, 1 stop bit (high), no parity.
REQ-015 rx_i SHALL pass through SYNC_STAGES flops reset to 1; all references to the line below mean the synchronized value.
REQ-016 States SHALL be IDLE, START, DATA, STOP, CRC_START, CRC_DATA, CRC_STOP, DONE.
REQ-017 IDLE -> START when rx_en_i=1, N>=2 and a 1->0 transition of the line is seen; N and crc_en_i SHALL be latched at this transition and used for the entire frame.
REQ-018 With N<2 or rx_en_i=0 the block SHALL stay in IDLE, ignoring the line.
REQ-019 START: line SHALL be sampled floor(N/2) cycles after the detected edge; low -> DATA, high -> IDLE (false start, no output pulse).
REQ-020 Each subsequent sample (data bits, stop bit) SHALL occur exactly N cycles after the previous sample; the bit counter SHALL be 16 bits and reload on every sample.
REQ-021 DATA: 8 samples shifted in LSB first, then -> STOP.
REQ-022 STOP sample low: frame_err_o pulses next cycle, no rx_valid_o, rx_data_o unchanged, -> IDLE.
REQ-023 STOP sample high with latched crc_en=0: -> DONE; DONE lasts one cycle, asserting rx_valid_o and loading rx_data_o, then -> IDLE.
REQ-024 STOP sample high with latched crc_en=1: -> CRC_START, which waits for the next falling edge (no timeout) and then applies REQ-019/020 to receive a second byte (CRC_DATA, CRC_STOP).
REQ-025 CRC SHALL be CRC-8, MSB-first, init 8'h00, no reflection, no final XOR, computed over the single data byte; the received second byte is the reference.
REQ-026 CRC_STOP high -> DONE: rx_valid_o pulses, rx_data_o loads the data byte, crc_err_o pulses in the same cycle if computed CRC != received byte.
REQ-027 CRC_STOP low -> frame_err_o pulse, no rx_valid_o, -> IDLE.
REQ-028 rx_en_i deasserting in any state SHALL force IDLE on the next edge with no output pulses; rx_data_o retained.
REQ-029 Falling edges occurring outside IDLE/CRC_START SHALL be ignored for start detection.
REQ-030 After DONE or any error, a new start SHALL only be detected on a fresh 1->0 transition.
REQ-031 rx_valid_o, frame_err_o, crc_err_o SHALL never be high for more than one consecutive cycle; rx_valid_o and frame_err_o SHALL never be high together.

Reset
REQ-032 On rst_i=1 at a clk edge: state IDLE, rx_data_o=8'h00, rx_valid_o=0, frame_err_o=0, crc_err_o=0, busy_o=0, synchronizer flops=1, counters and shift registers=0.
REQ-033 Reset mid-frame SHALL abort the frame with no output pulse; the first frame after release SHALL be received correctly.

Verification
REQ-034 N=16, crc_en=0, send 0xA5 -> one rx_valid_o pulse, rx_data_o=0xA5, no error pulses; pulse 1 cycle after stop-bit mid-sample.
REQ-035 N=16, crc_en=1, send 0xA5 then 0x72 -> rx_valid_o with rx_data_o=0xA5, crc_err_o=0; repeat with 0x73 -> rx_valid_o plus crc_err_o, rx_data_o=0xA5.
REQ-036 N=16, send 0x3C with stop bit low -> frame_err_o pulse, no rx_valid_o, rx_data_o keeps previous value.
REQ-037 N=16, 4-cycle low glitch on idle line -> no output pulses, busy_o returns low after floor(16/2) cycles.
REQ-038 N=16, drop rx_en_i at data bit 4 of 0x55, then reassert and send 0x0F -> no pulse for first frame, rx_data_o=0x0F after second.
REQ-039 Assert rst_i at data bit 3 of a frame, release, send 0x81 -> outputs zero during reset, then rx_valid_o with rx_data_o=0x81.
